// File: rtl/axis_noc_ingress_shim.sv
// axis_noc_ingress_shim: AXI-Stream to router ingress FIFO with per-packet tid/tdest hold and length cap; AXIS_INGRESS_STATS_EN adds stat counters
module axis_noc_ingress_shim #(
  parameter int TDATA_WIDTH   = 32,
  parameter int TID_WIDTH     = 2,
  parameter int TDEST_WIDTH   = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic                   clk_usr,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [TID_WIDTH-1:0]   s_axis_tid,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [TID_WIDTH-1:0]   m_axis_tid,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic [15:0]            stat_pkts,
  output logic [15:0]            stat_trunc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_PKT_FLITS + 1);
  localparam int EW = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TID_WIDTH-1:0] tid_q, tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] occ_q, occ_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] wr_ent, head;
  logic full, s_hs, m_hs, push, first, cap;
  assign full = occ_q == (PW+1)'(FIFO_DEPTH);
  assign s_axis_tready = !rst && (st_q == DROP || !full);
  assign m_axis_tvalid = occ_q != '0;
  assign head = m_axis_tvalid ? mem_q[rp_q] : '0;
  assign {m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tdest} = head;
  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;
  assign push = s_hs && st_q != DROP;
  assign first = st_q == IDLE;
  assign cap = st_q == IN_PKT && cnt_q == CW'(MAX_PKT_FLITS - 1) && !s_axis_tlast;
  assign wr_ent = {s_axis_tdata, s_axis_tlast || cap,
                   first ? s_axis_tid : tid_q, first ? s_axis_tdest : tdest_q};
  // next packet state, header latch and FIFO pointers
  always_comb begin
    tid_d = (s_hs && first) ? s_axis_tid : tid_q;
    tdest_d = (s_hs && first) ? s_axis_tdest : tdest_q;
    cnt_d = !s_hs ? cnt_q : (st_q == DROP || s_axis_tlast || cap) ? '0 : cnt_q + CW'(1);
    st_d = !s_hs ? st_q :
           st_q == DROP ? (s_axis_tlast ? IDLE : DROP) :
           s_axis_tlast ? IDLE : cap ? DROP : IN_PKT;
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(m_hs);
    occ_d = occ_q + (PW+1)'(push) - (PW+1)'(m_hs);
  end
  // control registers; reset discards any partial packet
  always_ff @(posedge clk_usr) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      tid_q <= '0;
      tdest_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      tid_q <= tid_d;
      tdest_q <= tdest_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      occ_q <= occ_d;
    end
  end
  // flit storage; empty slots are masked at the output so no reset is needed
  always_ff @(posedge clk_usr) begin
    if (push) mem_q[wp_q] <= wr_ent;
  end
`ifdef AXIS_INGRESS_STATS_EN
  logic [15:0] pkts_q, pkts_d, trc_q, trc_d;
  // saturating delivered/truncated packet counts
  always_comb begin
    pkts_d = pkts_q + 16'(m_hs && m_axis_tlast && pkts_q != 16'hFFFF);
    trc_d = trc_q + 16'(push && cap && trc_q != 16'hFFFF);
  end
  // counter registers
  always_ff @(posedge clk_usr) begin
    if (rst) begin
      pkts_q <= '0;
      trc_q <= '0;
    end else begin
      pkts_q <= pkts_d;
      trc_q <= trc_d;
    end
  end
  assign stat_pkts = pkts_q;
  assign stat_trunc = trc_q;
`else
  assign stat_pkts = '0;
  assign stat_trunc = '0;
`endif
endmodule

// File: tb/tb_axis_noc_ingress_shim.sv
// tb_axis_noc_ingress_shim: directed plus randomized check of the ingress shim against a queue model
module tb_axis_noc_ingress_shim;
`ifdef AXIS_INGRESS_STATS_EN
  localparam bit STATS = 1;
`else
  localparam bit STATS = 0;
`endif
  localparam int DEPTH = 4;
  localparam int MAXF = 16;
  typedef struct packed {logic [31:0] d; logic l; logic [1:0] id; logic [3:0] de;} flit_t;
  logic clk_usr = 0, rst = 1;
  logic s_tvalid = 0, s_tready, s_tlast = 0, m_tvalid, m_tready = 1, m_tlast;
  logic [31:0] s_tdata = 0, m_tdata;
  logic [1:0] s_tid = 0, m_tid;
  logic [3:0] s_tdest = 0, m_tdest;
  logic [15:0] stat_pkts, stat_trunc;
  flit_t q[$], log_q[$];
  bit drop = 0, rnd = 0;
  int fn = 0, mp = 0, mt = 0, s_acc = 0, vec = 0, err = 0, base;
  logic [1:0] lid = 0;
  logic [3:0] lde = 0;

  axis_noc_ingress_shim dut (
    .clk_usr(clk_usr), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .stat_pkts(stat_pkts), .stat_trunc(stat_trunc)
  );

  always #5 clk_usr = ~clk_usr;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  // compare DUT against the model, then advance the model by the handshakes of this cycle
  always @(negedge clk_usr) begin : cmp
    logic er, mv;
    flit_t f;
    er = rst ? 1'b0 : (drop || q.size() < DEPTH);
    mv = q.size() != 0;
    chk("s_tready", s_tready, er);
    chk("m_tvalid", m_tvalid, mv);
    if (mv) chk("m_flit", {m_tdata, m_tlast, m_tid, m_tdest}, q[0]);
    chk("stat_pkts", stat_pkts, STATS ? mp : 0);
    chk("stat_trunc", stat_trunc, STATS ? mt : 0);
    if (rst) begin
      q.delete();
      drop = 0; fn = 0; mp = 0; mt = 0;
    end else begin
      if (mv && m_tready) begin
        f = q.pop_front();
        log_q.push_back(f);
        if (f.l && mp < 65535) mp++;
      end
      if (s_tvalid && er) begin
        s_acc++;
        if (drop) begin
          if (s_tlast) drop = 0;
        end else begin
          if (fn == 0) begin lid = s_tid; lde = s_tdest; end
          fn++;
          f = '{d: s_tdata, l: s_tlast || fn == MAXF, id: lid, de: lde};
          q.push_back(f);
          if (s_tlast) fn = 0;
          else if (fn == MAXF) begin
            fn = 0; drop = 1;
            if (mt < 65535) mt++;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l, input logic [1:0] id, input logic [3:0] de);
    int n = 0;
    s_tvalid = 1; s_tdata = d; s_tlast = l; s_tid = id; s_tdest = de;
    do begin @(negedge clk_usr); n++; end while (!s_tready && n < 300);
    if (!s_tready) begin
      err++;
      $display("FAIL send_timeout: s_tready stuck at 0, required 1");
    end
    @(posedge clk_usr); #1;
    s_tvalid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_usr);
    #1;
  endtask

  task automatic clr();
    log_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk_usr);
    @(negedge clk_usr);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_flit", {m_tdata, m_tlast, m_tid, m_tdest}, 0);
    chk("rst_stats", {stat_pkts, stat_trunc}, 0);
    @(posedge clk_usr); #1 rst = 0;
    // 1: basic 3-flit packet
    clr();
    for (int i = 0; i < 3; i++) send(32'hA0 + i, i == 2, 2'd1, 4'd5);
    idle(4);
    chk("t1_count", log_q.size(), 3);
    chk("t1_f0", log_q[0], {32'hA0, 1'b0, 2'd1, 4'd5});
    chk("t1_f1_last", log_q[1].l, 0);
    chk("t1_f2", log_q[2], {32'hA2, 1'b1, 2'd1, 4'd5});
    // 2: header held for the whole packet
    clr();
    send(32'hB0, 0, 2'd1, 4'd5);
    send(32'hB1, 0, 2'd2, 4'd9);
    send(32'hB2, 1, 2'd2, 4'd9);
    send(32'hC0, 1, 2'd0, 4'd9);
    idle(4);
    chk("t2_f1_dest", log_q[1].de, 5);
    chk("t2_f2_dest_id", {log_q[2].de, log_q[2].id}, {4'd5, 2'd1});
    chk("t2_next_dest", {log_q[3].de, log_q[3].id, log_q[3].l}, {4'd9, 2'd0, 1'b1});
    // 3: backpressure fills the FIFO
    clr();
    m_tready = 0;
    base = s_acc;
    fork
      for (int i = 0; i < 6; i++) send(32'hD0 + i, i == 5, 2'd0, 4'd2);
    join_none
    repeat (12) @(negedge clk_usr);
    #1;
    chk("t3_accepted", s_acc - base, 4);
    chk("t3_s_tready", s_tready, 0);
    chk("t3_frozen", m_tdata, 32'hD0);
    @(posedge clk_usr); #1 m_tready = 1;
    wait fork;
    idle(6);
    chk("t3_count", log_q.size(), 6);
    chk("t3_order", {log_q[3].d, log_q[5].d, log_q[5].l}, {32'hD3, 32'hD5, 1'b1});
    // 4: truncation of a 20-flit packet
    clr();
    base = s_acc;
    for (int i = 0; i < 20; i++) send(32'hE0 + i, i == 19, 2'd3, 4'd1);
    idle(6);
    chk("t4_count", log_q.size(), 16);
    chk("t4_f15", log_q[15], {32'hEF, 1'b1, 2'd3, 4'd1});
    chk("t4_f14_last", log_q[14].l, 0);
    chk("t4_accepted", s_acc - base, 20);
    chk("t4_trunc", stat_trunc, STATS ? 1 : 0);
    chk("t4_pkts", stat_pkts, STATS ? 5 : 0);
    // 5: exactly MAX flits is not truncated
    clr();
    for (int i = 0; i < 16; i++) send(32'hF0 + i, i == 15, 2'd0, 4'd3);
    send(32'h77, 1, 2'd3, 4'd7);
    idle(6);
    chk("t5_count", log_q.size(), 17);
    chk("t5_f15_last", log_q[15].l, 1);
    chk("t5_next", {log_q[16].de, log_q[16].id}, {4'd7, 2'd3});
    chk("t5_trunc", stat_trunc, STATS ? 1 : 0);
    chk("t5_pkts", stat_pkts, STATS ? 7 : 0);
    // 6: reset mid-packet
    m_tready = 0;
    send(32'h51, 0, 2'd1, 4'd4);
    send(32'h52, 0, 2'd1, 4'd4);
    rst = 1;
    @(posedge clk_usr); #1 rst = 0;
    m_tready = 1;
    @(negedge clk_usr);
    chk("t6_m_tvalid", m_tvalid, 0);
    @(posedge clk_usr); #1;
    clr();
    send(32'h61, 0, 2'd2, 4'd6);
    send(32'h62, 1, 2'd0, 4'd0);
    idle(4);
    chk("t6_count", log_q.size(), 2);
    chk("t6_f0", log_q[0], {32'h61, 1'b0, 2'd2, 4'd6});
    chk("t6_f1", log_q[1], {32'h62, 1'b1, 2'd2, 4'd6});
    // random traffic with random backpressure
    rnd = 1;
    fork
      while (rnd) begin
        @(posedge clk_usr); #1;
        m_tready = ($urandom % 4) != 0;
      end
    join_none
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 22);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 1) * $urandom_range(0, 2));
        send($urandom, i == len - 1, 2'($urandom), 4'($urandom));
      end
    end
    rnd = 0;
    @(posedge clk_usr); #2 m_tready = 1;
    idle(10);
    chk("rnd_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
